// File: rtl/timer_arb_pkg.sv
// Shared types and constants for the timer arbiter: FSM state encoding and tick divisors.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int TICK_DIV_DEFAULT = 100_000_000;
  localparam int TICK_DIV_SIM     = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Coarse tick generator: prescaler wrapping every TICK_DIV cycles plus a tick counter
// that flags the wrap on which the requested duration completes.
module tick_prescaler
  import timer_arb_pkg::*;
#(
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DUR_W-1:0] dur,
  output logic             tick,
  output logic             last
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [DUR_W:0]   cnt_p1;

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    cnt_p1 = {1'b0, cnt_q} + {{DUR_W{1'b0}}, 1'b1};
    tick   = en && (pre_q == PRE_W'(TICK_DIV - 1));
    last   = tick && (cnt_p1 == {1'b0, dur});
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        pre_d = '0;
        // Hold on the final wrap so the counter can never roll over.
        if (!last) cnt_d = cnt_p1[DUR_W-1:0];
      end else begin
        pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one coarse-tick countdown timer among N_REQ requesters.
// Optional owner abort via `cancel` when TIMER_ARB_CANCEL_EN is defined.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur,
`ifdef TIMER_ARB_CANCEL_EN
  input  logic [N_REQ-1:0]       cancel,
`endif
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  // Handshake: req[i] is a level held until done[i]; it is only sampled in IDLE.
  // grant[owner] is high through LOAD/RUN, done[owner] pulses for the single DONE cycle.
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [DUR_W-1:0] dur_q, dur_d;

  logic [IDX_W-1:0] pick;
  logic             found;
  logic [IDX_W-1:0] next_ptr;
  logic [N_REQ-1:0] owner_oh;
  logic             cancel_hit;
  logic             tick_unused;
  logic             last;
  int               j;

  tick_prescaler #(
    .DUR_W    (DUR_W),
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == LOAD),
    .en    (state_q == RUN),
    .dur   (dur_q),
    .tick  (tick_unused),
    .last  (last)
  );

  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    // First set request at or above rr_q, wrapping around.
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  always_comb begin
    next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + {{(IDX_W-1){1'b0}}, 1'b1};
    owner_oh = N_REQ'(1) << owner_q;
`ifdef TIMER_ARB_CANCEL_EN
    cancel_hit = cancel[owner_q];
`else
    cancel_hit = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    dur_d   = dur_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          dur_d   = dur[int'(pick)*DUR_W +: DUR_W];
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cancel_hit) begin
          rr_d    = next_ptr;
          state_d = IDLE;
        end else if (dur_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cancel_hit) begin
          rr_d    = next_ptr;
          state_d = IDLE;
        end else if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rr_d    = next_ptr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      dur_q   <= dur_d;
    end
  end

  always_comb begin
    grant     = ((state_q == LOAD) || (state_q == RUN)) ? owner_oh : '0;
    done      = (state_q == DONE) ? owner_oh : '0;
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter with TICK_DIV=4, N_REQ=4, DUR_W=8.
module tb_timer_arbiter;
  import timer_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] dur;
  logic [N-1:0]  cancel;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          busy;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int t      = 0;
  int done_cnt;

  timer_arbiter #(
    .N_REQ    (N),
    .DUR_W    (DW),
    .TICK_DIV (TICK_DIV_SIM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .dur       (dur),
`ifdef TIMER_ARB_CANCEL_EN
    .cancel    (cancel),
`endif
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to cycle c (relative to the last start), sampling at the falling edge.
  task automatic goto(input int c);
    while (t < c) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic start();
    @(negedge clk);
    t = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("done_onehot0", 32'($onehot0(done)), 32'd1);
    end
  end

  initial begin
    reset  = 1'b1;
    req    = '0;
    dur    = '0;
    cancel = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;

    // Single request, dur=3
    start();
    dur[7:0] = 8'd3; req = 4'b0001;
    goto(1);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_load", 32'(dbg_state), 32'(LOAD));
    check("t1_busy", 32'(busy), 32'h1);
    goto(2);
    check("t1_run", 32'(dbg_state), 32'(RUN));
    goto(13);
    check("t1_done_early", 32'(done), 32'h0);
    goto(14);
    check("t1_done", 32'(done), 32'h1);
    check("t1_grant_off", 32'(grant), 32'h0);
    req = 4'b0000;
    goto(15);
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);

    // Clear rr pointer, then simultaneous requests 0 and 2
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start();
    dur[7:0] = 8'd1; dur[23:16] = 8'd1; req = 4'b0101;
    goto(1);
    check("t2_grant0", 32'(grant), 32'h1);
    goto(6);
    check("t2_done0", 32'(done), 32'h1);
    req[0] = 1'b0;
    goto(7);
    req[0] = 1'b1;
    goto(8);
    check("t2_grant2", 32'(grant), 32'h4);
    goto(13);
    check("t2_done2", 32'(done), 32'h4);
    req[2] = 1'b0;
    goto(15);
    check("t2_grant0_again", 32'(grant), 32'h1);
    goto(20);
    check("t2_done0_again", 32'(done), 32'h1);
    req = 4'b0000;
    goto(22);

    // dur = 0 and dur = 255 on requester 1
    start();
    dur[15:8] = 8'd0; req = 4'b0010;
    goto(1);
    check("t3_grant1", 32'(grant), 32'h2);
    goto(2);
    check("t3_done_dur0", 32'(done), 32'h2);
    check("t3_grant_off", 32'(grant), 32'h0);
    req = 4'b0000;
    goto(4);
    start();
    dur[15:8] = 8'd255; req = 4'b0010;
    goto(1021);
    check("t3_done255_early", 32'(done), 32'h0);
    goto(1022);
    check("t3_done255", 32'(done), 32'h2);
    req = 4'b0000;
    goto(1023);
    check("t3_idle", 32'(busy), 32'h0);

    // Reset in the middle of a run
    start();
    dur[23:16] = 8'd3; req = 4'b0100;
    goto(6);
    reset = 1'b1; req = 4'b0000;
    goto(7);
    reset = 1'b0;
    check("t4_grant", 32'(grant), 32'h0);
    check("t4_done", 32'(done), 32'h0);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_state", 32'(dbg_state), 32'(IDLE));
    done_cnt = 0;
    for (int c = 8; c <= 20; c++) begin
      goto(c);
      if (done != '0) done_cnt++;
    end
    check("t4_no_done", 32'(done_cnt), 32'd0);
    start();
    dur[15:8] = 8'd1; dur[31:24] = 8'd1; req = 4'b1010;
    goto(1);
    check("t4_rr_reset", 32'(grant), 32'h2);
    goto(6);
    check("t4_done1", 32'(done), 32'h2);
    req[1] = 1'b0;
    goto(8);
    check("t4_grant3", 32'(grant), 32'h8);
    goto(13);
    check("t4_done3", 32'(done), 32'h8);
    req = 4'b0000;
    goto(15);

    // Owner cancel with requester 1 pending
    start();
    dur[7:0] = 8'd3; dur[15:8] = 8'd1; req = 4'b0001;
    goto(2);
    req[1] = 1'b1;
    goto(5);
    cancel = 4'b0001;
    goto(6);
    cancel = 4'b0000;
`ifdef TIMER_ARB_CANCEL_EN
    check("t5_cancel_grant", 32'(grant), 32'h0);
    check("t5_cancel_busy", 32'(busy), 32'h0);
    check("t5_cancel_done", 32'(done), 32'h0);
    req[0] = 1'b0;
    goto(7);
    check("t5_grant1", 32'(grant), 32'h2);
    goto(12);
    check("t5_done1", 32'(done), 32'h2);
    req = 4'b0000;
    goto(14);
`else
    check("t5_nocancel_grant", 32'(grant), 32'h1);
    goto(14);
    check("t5_done0", 32'(done), 32'h1);
    req[0] = 1'b0;
    goto(16);
    check("t5_grant1", 32'(grant), 32'h2);
    goto(21);
    check("t5_done1", 32'(done), 32'h2);
    req = 4'b0000;
    goto(23);
`endif

    // Request dropped mid-run still completes
    start();
    dur[31:24] = 8'd2; req = 4'b1000;
    goto(4);
    req = 4'b0000;
    check("t6_run", 32'(dbg_state), 32'(RUN));
    goto(9);
    check("t6_done_early", 32'(done), 32'h0);
    goto(10);
    check("t6_done3", 32'(done), 32'h8);
    goto(11);
    check("t6_done_pulse", 32'(done), 32'h0);
    check("t6_idle", 32'(busy), 32'h0);

    goto(13);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
